// File: rtl/uart_pkg.sv
// Shared UART constants: clocking, ASCII control codes and the TX feeder FSM encoding.
// Used by the TX feeder, the transmitter and the future receiver.
package uart_pkg;

    localparam int unsigned CLK_FREQ   = 10_000_000;
    localparam int unsigned BAUD_RATE  = 115_200;
    // Rounded to nearest: 10 MHz / 115200 = 86.8 -> 87 clocks per bit.
    localparam int unsigned BIT_PERIOD = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE      = 2'd0;
    localparam tx_state_t ST_LAUNCH    = 2'd1;
    localparam tx_state_t ST_WAIT_BUSY = 2'd2;
    localparam tx_state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Start/data/busy handshake between the TX feeder (master) and the UART transmitter (slave).
interface uart_tx_feeder_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Byte FIFO for the UART TX path: registered count drives full/empty, no write-to-read bypass,
// one-cycle overflow pulse on a dropped write, synchronous flush.
module uart_sync_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic              flush,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    assign full     = (count_q == (ADDR_W + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // A write while full is refused even if a pop frees a slot this cycle.
    assign push = wr_en && !full && !flush;
    assign pop  = rd_en && !empty;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_en && full && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers CPU bytes and feeds them one at a time to the UART transmitter.
// Optional UART_TX_CRLF_EN: insert a CR before every LF taken from the FIFO.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    uart_tx_feeder_if.master  tx_if
);

    tx_state_t  state_q, state_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] head;
    logic       pop;

`ifdef UART_TX_CRLF_EN
    logic       cr_sent_q, cr_sent_d;
`endif

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .flush    (flush),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
`ifdef UART_TX_CRLF_EN
        cr_sent_d = cr_sent_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_if.tx_busy) begin
                    state_d = ST_LAUNCH;
`ifdef UART_TX_CRLF_EN
                    // The LF stays at the head while its CR goes out first.
                    if (head == ASCII_LF && !cr_sent_q) begin
                        tx_data_d = ASCII_CR;
                        cr_sent_d = 1'b1;
                    end else begin
                        tx_data_d = head;
                        pop       = 1'b1;
                        cr_sent_d = 1'b0;
                    end
`else
                    tx_data_d = head;
                    pop       = 1'b1;
`endif
                end
            end
            ST_LAUNCH:    state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_if.tx_busy) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_if.tx_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
`ifdef UART_TX_CRLF_EN
        if (flush) begin
            cr_sent_d = 1'b0;
        end
`endif
        tx_start_d = (state_d == ST_LAUNCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_TX_CRLF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_sent_q <= 1'b0;
        end else begin
            cr_sent_q <= cr_sent_d;
        end
    end
`endif

    assign tx_if.tx_start = tx_start_q;
    assign tx_if.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural 8N1 transmitter on the handshake.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              wr_en   = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              flush   = 1'b0;
    logic              full, empty, overflow;
    logic [ADDR_W:0]   count;

    uart_tx_feeder_if tif ();

    uart_tx_feeder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_if    (tif)
    );

    always #5 clk = ~clk;

    // Behavioural transmitter; it has its own reset domain and ignores rst_n.
    logic        model_busy = 1'b0;
    logic        hold_busy  = 1'b0;
    logic        tx_line    = 1'b1;
    int unsigned clk_cnt    = 0;
    int unsigned bit_idx    = 0;
    logic [9:0]  frame      = '1;
    logic [7:0]  sent_q[$];

    assign tif.tx_busy = model_busy | hold_busy;

    always @(posedge clk) begin
        if (!model_busy) begin
            if (tif.tx_start) begin
                model_busy <= 1'b1;
                frame      <= {1'b1, tif.tx_data, 1'b0};
                tx_line    <= 1'b0;
                clk_cnt    <= 0;
                bit_idx    <= 0;
                sent_q.push_back(tif.tx_data);
            end
        end else if (clk_cnt == BIT_PERIOD - 1) begin
            clk_cnt <= 0;
            if (bit_idx == 9) begin
                model_busy <= 1'b0;
                tx_line    <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 1;
                tx_line <= frame[bit_idx + 1];
            end
        end else begin
            clk_cnt <= clk_cnt + 1;
        end
    end

    int         start_cnt  = 0;
    int         start_viol = 0;
    int         data_viol  = 0;
    int         ovf_cnt    = 0;
    logic       prev_start = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (tif.tx_start) start_cnt++;
        if (tif.tx_start && prev_start) start_viol++;
        if (rst_n && tif.tx_data != prev_data && !tif.tx_start) data_viol++;
        if (overflow) ovf_cnt++;
        prev_start = tif.tx_start;
        prev_data  = tif.tx_data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget);
        int k = 0;
        while (sent_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_sent", sent_q.size(), n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (model_busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("tx_idle", model_busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_frame;
        int s0, st0, o0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_tx_start", tif.tx_start, 0);
        check_eq("rst_tx_data", tif.tx_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte: latency and line waveform
        st0 = start_cnt;
        write_byte(8'h55);
        check_eq("t1_count", count, 1);
        check_eq("t1_start_early", tif.tx_start, 0);
        @(negedge clk);
        check_eq("t1_start", tif.tx_start, 1);
        check_eq("t1_data", tif.tx_data, 8'h55);
        check_eq("t1_empty", empty, 1);
        @(negedge clk);
        check_eq("t1_start_drop", tif.tx_start, 0);
        exp_frame = {1'b1, 8'h55, 1'b0};
        repeat (BIT_PERIOD / 2) @(negedge clk);
        check_eq("t1_line_b0", tx_line, exp_frame[0]);
        for (int i = 1; i < 10; i++) begin
            repeat (BIT_PERIOD) @(negedge clk);
            check_eq($sformatf("t1_line_b%0d", i), tx_line, exp_frame[i]);
        end
        wait_idle();
        check_eq("t1_starts", start_cnt - st0, 1);

        // Burst of three
        hold_busy = 1'b1;
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        check_eq("t2_count", count, 3);
        check_eq("t2_empty", empty, 0);
        s0 = sent_q.size();
        hold_busy = 1'b0;
        wait_sent(s0 + 3, 4000);
        check_eq("t2_b0", sent_q[s0], 8'h41);
        check_eq("t2_b1", sent_q[s0 + 1], 8'h42);
        check_eq("t2_b2", sent_q[s0 + 2], 8'h43);
        check_eq("t2_empty_end", empty, 1);
        wait_idle();

        // Overflow on the ninth write
        hold_busy = 1'b1;
        o0 = ovf_cnt;
        for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
        check_eq("t3_full", full, 1);
        check_eq("t3_count8", count, 8);
        check_eq("t3_no_ovf", overflow, 0);
        write_byte(8'h18);
        check_eq("t3_ovf", overflow, 1);
        check_eq("t3_count_hold", count, 8);
        @(negedge clk);
        check_eq("t3_ovf_drop", overflow, 0);
        s0 = sent_q.size();
        hold_busy = 1'b0;
        wait_sent(s0 + 8, 8000);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t3_b%0d", i), sent_q[s0 + i], 8'h10 + 8'(i));
        end
        wait_idle();
        repeat (200) @(negedge clk);
        check_eq("t3_no_extra", sent_q.size(), s0 + 8);
        check_eq("t3_ovf_pulses", ovf_cnt - o0, 1);

        // Flush with one in flight and five queued
        for (int i = 0; i < 6; i++) write_byte(8'h20 + 8'(i));
        check_eq("t4_count5", count, 5);
        o0 = ovf_cnt;
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        check_eq("t4_count0", count, 0);
        check_eq("t4_empty", empty, 1);
        check_eq("t4_no_ovf", overflow, 0);
        s0  = sent_q.size();
        st0 = start_cnt;
        check_eq("t4_inflight", sent_q[s0 - 1], 8'h20);
        wait_idle();
        repeat (300) @(negedge clk);
        check_eq("t4_no_more_tx", sent_q.size(), s0);
        check_eq("t4_no_start", start_cnt - st0, 0);
        check_eq("t4_ovf_pulses", ovf_cnt - o0, 0);

        // Reset in WAIT_DONE
        write_byte(8'h77);
        repeat (20) @(negedge clk);
        write_byte(8'h78);
        write_byte(8'h79);
        check_eq("t5_pre_count", count, 2);
        check_eq("t5_pre_data", tif.tx_data, 8'h77);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_start", tif.tx_start, 0);
        check_eq("t5_rst_data", tif.tx_data, 8'h00);
        check_eq("t5_rst_count", count, 0);
        check_eq("t5_rst_empty", empty, 1);
        check_eq("t5_rst_full", full, 0);
        check_eq("t5_rst_ovf", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = sent_q.size();
        write_byte(8'h3C);
        wait_sent(s0 + 1, 2000);
        check_eq("t5_after_rst", sent_q[s0], 8'h3C);
        wait_idle();

        // CR/LF handling
        s0 = sent_q.size();
        write_byte(8'h68);
        write_byte(8'h0A);
`ifdef UART_TX_CRLF_EN
        wait_sent(s0 + 3, 4000);
        check_eq("t6_b0", sent_q[s0], 8'h68);
        check_eq("t6_b1", sent_q[s0 + 1], 8'h0D);
        check_eq("t6_b2", sent_q[s0 + 2], 8'h0A);
        wait_idle();
        repeat (50) @(negedge clk);
        check_eq("t6_total", sent_q.size(), s0 + 3);
`else
        wait_sent(s0 + 2, 3000);
        check_eq("t6_b0", sent_q[s0], 8'h68);
        check_eq("t6_b1", sent_q[s0 + 1], 8'h0A);
        wait_idle();
        repeat (50) @(negedge clk);
        check_eq("t6_total", sent_q.size(), s0 + 2);
`endif
        check_eq("t6_empty", empty, 1);

        check_eq("start_single_cycle", start_viol, 0);
        check_eq("data_stable", data_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
